wb_bus_arbiter: RTL and testbench
=================================

# wb_bus_arbiter

Round-robin arbiter for the shared WISHBONE bus. It takes the CYC_O request of every bus master, including the NIC's WISHBONE master interface, and drives the one-hot grant that each master sees as `gnt_wb_i`. It sits beside the bus interconnect. It also runs a watchdog that flags a granted cycle which never terminates.

## Interface
- `N_MASTERS`, 4: number of requesting masters.
- `N_BITS_MASTER_ID`, 2: width of master index. Must satisfy 2**N_BITS_MASTER_ID >= N_MASTERS.
- `N_BITS_TIMEOUT`, 8: width of the watchdog counter.
- `TIMEOUT_CYCLES`, 255: watchdog limit. 0 disables the watchdog. Must fit in N_BITS_TIMEOUT.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cyc_i`  in  N_MASTERS  CYC_O of each master; bit i belongs to master i.
- `ACK_I`  in  1  bus ACK (slave side, after interconnect mux).
- `ERR_I`  in  1  bus ERR.
- `RTY_I`  in  1  bus RTY.
- `gnt_o`  out  N_MASTERS  one-hot grant, registered; bit i drives master i's `gnt_wb_i`.
- `gnt_id_o`  out  N_BITS_MASTER_ID  index of current owner, registered; the interconnect uses it for its mux select.
- `bus_busy_o`  out  1  high while a grant is held.
- `timeout_o`  out  1  one-cycle pulse on watchdog expiry. The system ORs it into the owner's ERR_I.

## Operation
- Three states:
  - IDLE: no grant.
  - BUSY: grant held.
  - RELEASE: one dead cycle after the owner drops CYC.
- Reset values:
  - state = IDLE
  - gnt_o = 0, gnt_id_o = 0, bus_busy_o = 0, timeout_o = 0
  - priority pointer `ptr` = 0
  - watchdog counter `wd_cnt` = 0
- Arbitration runs in IDLE and RELEASE.
  - Scan cyc_i starting at ptr, in the order ptr, ptr+1, …, N_MASTERS-1, 0, …, ptr-1. The first set bit wins.
  - If there is a winner: next state BUSY, gnt_o <= one-hot(winner), gnt_id_o <= winner, ptr <= winner+1, with ptr wrapping from N_MASTERS-1 to 0.
  - If there is no request: next state IDLE, gnt_o <= 0. gnt_id_o keeps its last value.
- BUSY:
  - Grant is held while cyc_i[gnt_id_o] = 1. Other masters' requests are ignored; there is no preemption.
  - When cyc_i[gnt_id_o] = 0 is sampled: next state RELEASE, gnt_o <= 0, bus_busy_o <= 0.
- RELEASE: gnt_o = 0. Arbitrates as described above, so back-to-back ownership is possible without passing through IDLE.
- Watchdog, BUSY only:
  - Clear the counter if any of the following: ACK_I, ERR_I or RTY_I = 1; owner CYC = 0; wd_cnt = TIMEOUT_CYCLES.
  - Otherwise wd_cnt <= wd_cnt+1.
  - wd_cnt is held at 0 outside BUSY.
  - timeout_o = (state == BUSY) && (TIMEOUT_CYCLES != 0) && (wd_cnt == TIMEOUT_CYCLES).
  - Timeout does not drop the grant. The owner sees ERR, must drop CYC, and release then follows the normal path.
- Simultaneous events:
  - Termination signal and counter limit in the same cycle: timeout_o still fires, since it is decoded from the registered count, and the counter clears.
  - Owner CYC falling in the same cycle: the same rule applies, and the RELEASE transition takes priority for next state.
- Unused cyc_i indices cannot exist. Any out-of-range ptr value resolves to 0.

## Timing
- Request latency: cyc_i[i] rises at cycle t while in IDLE, giving gnt_o[i] = 1 at t+1.
- Release-to-regrant: owner CYC sampled low at t, RELEASE at t+1 (gnt_o = 0), next owner granted at t+2. At least one grant-free cycle always separates two owners.
- gnt_o, gnt_id_o and bus_busy_o are all registered and change together on the same edge.
- Watchdog: with the owner stalled from the first grant cycle g (wd_cnt = 0 at g), timeout_o = 1 exactly at cycle g+TIMEOUT_CYCLES, then wd_cnt = 0 at the next cycle.
- Reset mid-cycle: rst sampled high forces all reset values at the next edge regardless of cyc_i. Arbitration resumes with ptr = 0 on the first cycle after rst deasserts.

## Test plan
- Single requester: cyc_i = 4'b0100 from IDLE at cycle 0 → gnt_o = 4'b0100 and gnt_id_o = 2 at cycle 1; ptr = 3. Drop cyc at cycle 5 → gnt_o = 0 at cycle 6.
- Fairness: all four masters hold cyc_i = 4'b1111 and each drops CYC 3 cycles after its grant → grant order 0,1,2,3,0, each separated by exactly one RELEASE cycle.
- Wrap-around: ptr = 3 (last owner 2) with cyc_i = 4'b0011 → master 0 granted, not 1; ptr becomes 1.
- Watchdog: TIMEOUT_CYCLES = 8, owner holds CYC with no ACK/ERR/RTY → timeout_o pulses once at grant+8 and grant is kept. An ACK at grant+5 in a rerun → no pulse, counter restarts from 0.
- Reset mid-ownership: rst = 1 for one cycle while master 1 is owner with cyc held → gnt_o = 0, bus_busy_o = 0, ptr = 0 after the edge. On the next cycle with cyc_i = 4'b1010, master 1 is regranted.
- Owner drop coincident with a new request: owner 0 drops CYC at t while master 3 raises CYC at t → RELEASE at t+1, gnt_o = 4'b1000 at t+2.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Round-robin WISHBONE bus arbiter with registered one-hot grant and a
// watchdog that flags a granted cycle that never terminates.
module wb_bus_arbiter #(
  parameter int unsigned N_MASTERS        = 4,
  parameter int unsigned N_BITS_MASTER_ID = 2,
  parameter int unsigned N_BITS_TIMEOUT   = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        cyc_i,
  input  logic                        ACK_I,
  input  logic                        ERR_I,
  input  logic                        RTY_I,
  output logic [N_MASTERS-1:0]        gnt_o,
  output logic [N_BITS_MASTER_ID-1:0] gnt_id_o,
  output logic                        bus_busy_o,
  output logic                        timeout_o
);

  localparam logic [N_BITS_TIMEOUT-1:0] WdLimit = N_BITS_TIMEOUT'(TIMEOUT_CYCLES);
  localparam bit                        WdEn    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e                      state_q, state_d;
  logic [N_MASTERS-1:0]        gnt_q, gnt_d;
  logic [N_BITS_MASTER_ID-1:0] gnt_id_q, gnt_id_d;
  logic [N_BITS_MASTER_ID-1:0] ptr_q, ptr_d;
  logic                        busy_q, busy_d;
  logic [N_BITS_TIMEOUT-1:0]   wd_cnt_q, wd_cnt_d;

  logic        found;
  int unsigned win;
  int unsigned ptr_eff;
  logic        owner_cyc;
  logic        term;

  // Rotating priority scan: first pass covers ptr..N-1, second pass 0..ptr-1.
  always_comb begin
    found   = 1'b0;
    win     = 0;
    ptr_eff = (32'(ptr_q) < N_MASTERS) ? 32'(ptr_q) : 0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (!found && (i >= ptr_eff) && cyc_i[i]) begin
        found = 1'b1;
        win   = i;
      end
    end
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (!found && (i < ptr_eff) && cyc_i[i]) begin
        found = 1'b1;
        win   = i;
      end
    end
  end

  // gnt_q is the one-hot of gnt_id_q while busy, so this is cyc_i[gnt_id_q].
  assign owner_cyc = |(cyc_i & gnt_q);
  assign term      = ACK_I | ERR_I | RTY_I;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    wd_cnt_d = '0;

    case (state_q)
      StBusy: begin
        if (!owner_cyc) begin
          state_d = StRelease;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
        if (term || !owner_cyc || (wd_cnt_q == WdLimit)) begin
          wd_cnt_d = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: begin
        if (found) begin
          state_d  = StBusy;
          gnt_d    = N_MASTERS'(1) << win;
          gnt_id_d = N_BITS_MASTER_ID'(win);
          ptr_d    = (win == N_MASTERS - 1) ? '0 : N_BITS_MASTER_ID'(win + 1);
          busy_d   = 1'b1;
        end else begin
          state_d = StIdle;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_id_o   = gnt_id_q;
  assign bus_busy_o = busy_q;
  // Decoded from the registered count so it fires even if a termination
  // arrives in the same cycle.
  assign timeout_o  = WdEn && (state_q == StBusy) && (wd_cnt_q == WdLimit);

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: reset, single request, wrap-around,
// reset mid-ownership, fairness, coincident drop/request and watchdog.
module tb_wb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] cyc_i;
  logic       ack, err, rty;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       bus_busy_o;
  logic       timeout_o;

  int vectors;
  int miscompares;

  wb_bus_arbiter #(
    .N_MASTERS       (4),
    .N_BITS_MASTER_ID(2),
    .N_BITS_TIMEOUT  (8),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cyc_i     (cyc_i),
    .ACK_I     (ack),
    .ERR_I     (err),
    .RTY_I     (rty),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .bus_busy_o(bus_busy_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] id,
                           input logic busy);
    chk({tag, ".gnt"}, 32'(gnt_o), 32'(g));
    chk({tag, ".id"}, 32'(gnt_id_o), 32'(id));
    chk({tag, ".busy"}, 32'(bus_busy_o), 32'(busy));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    cyc_i = 4'b0000;
    ack   = 1'b0;
    err   = 1'b0;
    rty   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_grant("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.timeout", 32'(timeout_o), 32'd0);

    // Single requester: master 2 from IDLE, held 4 more cycles, then dropped.
    cyc_i = 4'b0100;
    tick();
    chk_grant("single.grant", 4'b0100, 2'd2, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    chk_grant("single.hold", 4'b0100, 2'd2, 1'b1);
    cyc_i = 4'b0000;
    tick();
    chk_grant("single.release", 4'b0000, 2'd2, 1'b0);
    tick();
    chk_grant("single.idle_keeps_id", 4'b0000, 2'd2, 1'b0);

    // Wrap-around: ptr=3, requests from 0 and 1 -> master 0 wins, ptr -> 1.
    cyc_i = 4'b0011;
    tick();
    chk_grant("wrap.grant0", 4'b0001, 2'd0, 1'b1);
    cyc_i = 4'b0000;
    tick();
    tick();
    cyc_i = 4'b0011;
    tick();
    chk_grant("wrap.ptr1", 4'b0010, 2'd1, 1'b1);

    // Reset mid-ownership (ptr is 2 here; reset must bring it back to 0).
    cyc_i = 4'b0010;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    chk_grant("rst_mid.cleared", 4'b0000, 2'd0, 1'b0);
    cyc_i = 4'b1010;
    tick();
    chk_grant("rst_mid.regrant1", 4'b0010, 2'd1, 1'b1);
    cyc_i = 4'b0000;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Fairness: all request, each owner holds 3 grant cycles then drops.
    cyc_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      logic [1:0] m;
      m = 2'(n % 4);
      tick();
      chk_grant($sformatf("fair%0d.grant", n), 4'b0001 << m, m, 1'b1);
      tick();
      tick();
      chk_grant($sformatf("fair%0d.held", n), 4'b0001 << m, m, 1'b1);
      if (n < 4) begin
        cyc_i[m] = 1'b0;
        tick();
        chk_grant($sformatf("fair%0d.release", n), 4'b0000, m, 1'b0);
        cyc_i = 4'b1111;
      end
    end

    // Owner 0 drops while master 3 raises in the same cycle.
    cyc_i = 4'b0001;
    tick();
    cyc_i = 4'b1000;
    tick();
    chk_grant("coinc.release", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_grant("coinc.grant3", 4'b1000, 2'd3, 1'b1);

    // Watchdog: owner 3 stalled from its grant cycle g.
    chk("wd.g0", 32'(timeout_o), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("wd.g%0d", k), 32'(timeout_o), (k == 8) ? 32'd1 : 32'd0);
    end
    chk_grant("wd.grant_kept", 4'b1000, 2'd3, 1'b1);

    // Rerun with an ACK at grant+5: counter restarts, pulse moves to grant+14.
    cyc_i = 4'b0000;
    tick();
    chk_grant("wd2.release", 4'b0000, 2'd3, 1'b0);
    cyc_i = 4'b1000;
    tick();
    chk_grant("wd2.grant3", 4'b1000, 2'd3, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      ack = (k == 6);
      tick();
      chk($sformatf("wd2.g%0d", k), 32'(timeout_o), (k == 14) ? 32'd1 : 32'd0);
    end
    ack   = 1'b0;
    cyc_i = 4'b0000;
    tick();
    chk_grant("wd2.final_release", 4'b0000, 2'd3, 1'b0);
    chk("wd2.final_timeout", 32'(timeout_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
